// File: rtl/bwt_mem_request_queue.sv
// Request queue between the backward SMEM datapath and the BWT occurrence memory.
// Buffers k/l line-address pairs and issues them as one (merged) or two memory beats.
module bwt_mem_request_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 42,
  parameter int READ_NUM_W = 9,
  parameter int AF_MARGIN  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      request_valid,
  input  logic [ADDR_W-1:0]         addr_k,
  input  logic [ADDR_W-1:0]         addr_l,
  input  logic [READ_NUM_W-1:0]     read_num_in,
  output logic                      mem_req_valid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [READ_NUM_W+1:0]     mem_req_tag,
  input  logic                      mem_req_ready,
  output logic                      stall_req,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_K = 2'd1,
    SEND_L = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [ADDR_W-1:0]     mem_k_q    [DEPTH];
  logic [ADDR_W-1:0]     mem_l_q    [DEPTH];
  logic [READ_NUM_W-1:0] mem_rn_q   [DEPTH];
  logic                  mem_same_q [DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  more_after_pop;
  logic [1:0]            kl;
  logic [ADDR_W-1:0]     head_k;
  logic [ADDR_W-1:0]     head_l;
  logic [READ_NUM_W-1:0] head_rn;
  logic                  head_same;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign push      = request_valid && (!full || pop);
  assign head_k    = mem_k_q[rd_ptr_q];
  assign head_l    = mem_l_q[rd_ptr_q];
  assign head_rn   = mem_rn_q[rd_ptr_q];
  assign head_same = mem_same_q[rd_ptr_q];

  // When the head pops, a same-cycle push is always accepted, so the queue
  // stays non-empty if another entry is held or one is arriving right now.
  assign more_after_pop = (count_q > CNT_W'(1)) || request_valid;

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_tag   = '0;
    kl            = 2'b00;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = SEND_K;
      end
      SEND_K: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_k;
        kl            = head_same ? 2'b11 : 2'b01;
        mem_req_tag   = {head_rn, kl};
        if (mem_req_ready) begin
          if (head_same) begin
            pop     = 1'b1;
            state_d = more_after_pop ? SEND_K : IDLE;
          end else begin
            state_d = SEND_L;
          end
        end
      end
      SEND_L: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_l;
        kl            = 2'b10;
        mem_req_tag   = {head_rn, kl};
        if (mem_req_ready) begin
          pop     = 1'b1;
          state_d = more_after_pop ? SEND_K : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (request_valid && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_k_q[wr_ptr_q]    <= addr_k;
      mem_l_q[wr_ptr_q]    <= addr_l;
      mem_rn_q[wr_ptr_q]   <= read_num_in;
      mem_same_q[wr_ptr_q] <= (addr_k == addr_l);
    end
  end

  assign stall_req  = (count_q >= CNT_W'(DEPTH - AF_MARGIN));
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bwt_mem_request_queue.sv
// Self-checking bench for bwt_mem_request_queue: directed scenarios plus randomized
// traffic, with expected memory beats queued at push time and checked by a monitor.
module tb_bwt_mem_request_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 42;
  localparam int RW    = 9;
  localparam int TW    = RW + 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          request_valid;
  logic [AW-1:0] addr_k;
  logic [AW-1:0] addr_l;
  logic [RW-1:0] read_num_in;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          stall_req;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  beat_t expQ[$];
  int    modelCount;
  bit    modelOvf;
  int    nCompared;
  int    nMismatched;

  bwt_mem_request_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .READ_NUM_W(RW), .AF_MARGIN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .request_valid(request_valid),
    .addr_k(addr_k),
    .addr_l(addr_l),
    .read_num_in(read_num_in),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .stall_req(stall_req),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] randAddr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  // Called at posedge+1; drives one cycle of inputs, books the expected effect, returns at next posedge+1.
  task automatic applyStimulus(input bit rv, input logic [AW-1:0] k, input logic [AW-1:0] l,
                               input logic [RW-1:0] rn, input bit rdy);
    bit    pop;
    bit    accept;
    int    cntNext;
    bit    ovfNext;
    beat_t b;
    request_valid = rv;
    addr_k        = k;
    addr_l        = l;
    read_num_in   = rn;
    mem_req_ready = rdy;
    pop     = mem_req_valid && rdy && (expQ.size() > 0) && expQ[0].last;
    accept  = rv && ((modelCount < DEPTH) || pop);
    cntNext = modelCount;
    ovfNext = modelOvf;
    if (accept) begin
      if (k == l) begin
        b = '{addr: k, tag: {rn, 2'b11}, last: 1'b1};
        expQ.push_back(b);
      end else begin
        b = '{addr: k, tag: {rn, 2'b01}, last: 1'b0};
        expQ.push_back(b);
        b = '{addr: l, tag: {rn, 2'b10}, last: 1'b1};
        expQ.push_back(b);
      end
      cntNext++;
    end else if (rv) begin
      ovfNext = 1'b1;
    end
    if (pop) cntNext--;
    @(posedge clk);
    #1;
    modelCount    = cntNext;
    modelOvf      = ovfNext;
    request_valid = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(1'b0, '0, '0, '0, rdy);
  endtask

  task automatic resetDut();
    rst           = 1'b0;
    request_valid = 1'b0;
    mem_req_ready = 1'b0;
    #1;
    checkOutput("rstValid", mem_req_valid, 0);
    checkOutput("rstAddr", mem_req_addr, 0);
    checkOutput("rstTag", mem_req_tag, 0);
    checkOutput("rstStall", stall_req, 0);
    checkOutput("rstCount", fifo_count, 0);
    checkOutput("rstOverflow", overflow, 0);
    expQ.delete();
    modelCount = 0;
    modelOvf   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expQ.size() > 0; i++) idleCycle(1'b1);
    checkOutput("drainEmpty", expQ.size(), 0);
    idleCycle(1'b1);
    checkOutput("drainCount", fifo_count, 0);
  endtask

  // Monitor: scoreboard pops on each handshake; also tracks occupancy flags and hold stability.
  initial begin
    bit            holdPending;
    logic [AW-1:0] holdAddr;
    logic [TW-1:0] holdTag;
    beat_t         e;
    holdPending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        holdPending = 1'b0;
        continue;
      end
      checkOutput("count", fifo_count, modelCount);
      checkOutput("stall", stall_req, (modelCount >= DEPTH - 4));
      checkOutput("overflow", overflow, modelOvf);
      if (holdPending) begin
        checkOutput("holdValid", mem_req_valid, 1);
        checkOutput("holdAddr", mem_req_addr, holdAddr);
        checkOutput("holdTag", mem_req_tag, holdTag);
      end
      if (mem_req_valid && mem_req_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpectedBeat: got addr 0x%0h tag 0x%0h, expected no beat", mem_req_addr, mem_req_tag);
        end else begin
          e = expQ.pop_front();
          checkOutput("beatAddr", mem_req_addr, e.addr);
          checkOutput("beatTag", mem_req_tag, e.tag);
        end
      end
      holdPending = mem_req_valid && !mem_req_ready;
      holdAddr    = mem_req_addr;
      holdTag     = mem_req_tag;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] k;
    logic [AW-1:0] l;
    int            readyPct;
    nCompared     = 0;
    nMismatched   = 0;
    modelCount    = 0;
    modelOvf      = 1'b0;
    rst           = 1'b1;
    request_valid = 1'b0;
    mem_req_ready = 1'b0;
    addr_k        = '0;
    addr_l        = '0;
    read_num_in   = '0;
    #3;
    resetDut();

    $display("[TB] scenario: two-beat request latency");
    applyStimulus(1'b1, 42'h100, 42'h240, 9'd5, 1'b0);
    checkOutput("latNotYetValid", mem_req_valid, 0);
    checkOutput("latCount1", fifo_count, 1);
    idleCycle(1'b1);
    checkOutput("latValid", mem_req_valid, 1);
    checkOutput("latAddrK", mem_req_addr, 42'h100);
    checkOutput("latTagK", mem_req_tag, {9'd5, 2'b01});
    idleCycle(1'b1);
    checkOutput("latAddrL", mem_req_addr, 42'h240);
    checkOutput("latTagL", mem_req_tag, {9'd5, 2'b10});
    idleCycle(1'b1);
    checkOutput("latIdle", mem_req_valid, 0);
    checkOutput("latCount0", fifo_count, 0);

    $display("[TB] scenario: merged k==l request");
    applyStimulus(1'b1, 42'h3A0, 42'h3A0, 9'd7, 1'b0);
    idleCycle(1'b1);
    checkOutput("mergeAddr", mem_req_addr, 42'h3A0);
    checkOutput("mergeTag", mem_req_tag, {9'd7, 2'b11});
    idleCycle(1'b1);
    checkOutput("mergePopped", fifo_count, 0);
    checkOutput("mergeIdle", mem_req_valid, 0);

    $display("[TB] scenario: fill to stall and overflow, then drain");
    resetDut();
    for (int i = 0; i < 17; i++) begin
      k = randAddr();
      applyStimulus(1'b1, k, ~k, RW'(i + 1), 1'b0);
      if (i == 10) checkOutput("stallBelow", stall_req, 0);
      if (i == 11) checkOutput("stallAt12", stall_req, 1);
    end
    checkOutput("fullCount", fifo_count, 16);
    checkOutput("fullOverflow", overflow, 1);
    drain();
    checkOutput("overflowSticky", overflow, 1);

    $display("[TB] scenario: push during final beat with one entry");
    resetDut();
    applyStimulus(1'b1, 42'h500, 42'h600, 9'd3, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("sendLAddr", mem_req_addr, 42'h600);
    applyStimulus(1'b1, 42'h700, 42'h780, 9'd4, 1'b1);
    checkOutput("swapCount", fifo_count, 1);
    checkOutput("swapValid", mem_req_valid, 1);
    checkOutput("swapAddr", mem_req_addr, 42'h700);
    checkOutput("swapTag", mem_req_tag, {9'd4, 2'b01});
    drain();

    $display("[TB] scenario: randomized traffic");
    resetDut();
    readyPct = 50;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       readyPct = 15;
          1:       readyPct = 50;
          default: readyPct = 90;
        endcase
      end
      k = randAddr();
      l = ($urandom_range(0, 3) == 0) ? k : randAddr();
      applyStimulus($urandom_range(0, 99) < 60, k, l, RW'($urandom), $urandom_range(0, 99) < readyPct);
    end
    drain();

    $display("[TB] scenario: reset in the middle of a transfer");
    resetDut();
    for (int i = 0; i < 5; i++) begin
      k = randAddr();
      applyStimulus(1'b1, k, k + 42'd1, RW'(20 + i), 1'b0);
    end
    idleCycle(1'b1);
    checkOutput("midCount5", fifo_count, 5);
    checkOutput("midTagL", mem_req_tag[1:0], 2'b10);
    resetDut();
    for (int i = 0; i < 10; i++) begin
      idleCycle(1'b1);
      checkOutput("postRstValid", mem_req_valid, 0);
    end
    checkOutput("postRstCount", fifo_count, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
